data_sram_ctrl: RTL and testbench

- Memory-stage sequencer between the CPU MEM stage and the SRAM-like data port.
- Per load/store it:
  - checks alignment;
  - issues exactly one request on the data port, with size, byte strobes and lane-replicated write data;
  - tracks the addr_ok/data_ok handshake;
  - stalls the pipeline while the access is in flight;
  - returns sign/zero-extended load data held until WB accepts it.
- Sits between the MEM pipeline register and the top-level data SRAM interface.
- Absorbs responses belonging to flushed instructions.

---
 rtl/data_sram_ctrl.sv | 263 ++++++++++++++++++++++++++
 tb/tb_data_sram_ctrl.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_sram_ctrl.sv
// ---------------------------------------------------------------------------
// data_sram_ctrl
//   Memory-stage sequencer between the CPU MEM stage and an SRAM-like data
//   port. Each load/store is alignment-checked, then issues exactly one
//   request (size, strobes, lane-replicated write data), tracks the
//   addr_ok/data_ok handshake and returns extended load data that is held
//   until WB accepts it. Responses of flushed instructions are absorbed.
//
// Ports
//   clk, resetn            clock, asynchronous active-low reset
//   mem_valid/op/addr/wdata  MEM-stage access (op: 0 LB 1 LBU 2 LH 3 LHU
//                          4 LW 5 SB 6 SH 7 SW)
//   flush                  kill of the MEM-stage instruction
//   wb_allowin             WB takes the result this cycle
//   mem_stall              hold MEM and earlier stages
//   result_valid, load_data, adel, ades, badvaddr   result towards WB
//   data_req/wr/size/wstrb/addr/wdata               request to the SRAM port
//   data_addr_ok, data_rdata, data_data_ok          SRAM port responses
//   dbg_state              current FSM state (observation only)
//
// Handshake: a request is presented with data_req=1 and every data_* field
// stable until the cycle data_addr_ok is high; that cycle completes the
// address phase. data_data_ok (one cycle, with data_rdata for reads) always
// arrives in a later cycle and completes the access.
// ---------------------------------------------------------------------------
module data_sram_ctrl #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              mem_valid,
    input  logic [2:0]        mem_op,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_wdata,
    input  logic              flush,
    input  logic              wb_allowin,
    output logic              mem_stall,
    output logic              result_valid,
    output logic [31:0]       load_data,
    output logic              adel,
    output logic              ades,
    output logic [ADDR_W-1:0] badvaddr,
    output logic              data_req,
    output logic              data_wr,
    output logic [1:0]        data_size,
    output logic [3:0]        data_wstrb,
    output logic [ADDR_W-1:0] data_addr,
    output logic [31:0]       data_wdata,
    input  logic              data_addr_ok,
    input  logic [31:0]       data_rdata,
    input  logic              data_data_ok,
    output logic [2:0]        dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_REQ    = 3'd1,
        S_WAIT   = 3'd2,
        S_DONE   = 3'd3,
        S_CANCEL = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [2:0]        op_q, op_d;
    logic              flush_seen_q, flush_seen_d;
    logic              data_req_q, data_req_d;
    logic              data_wr_q, data_wr_d;
    logic [1:0]        data_size_q, data_size_d;
    logic [3:0]        data_wstrb_q, data_wstrb_d;
    logic [ADDR_W-1:0] data_addr_q, data_addr_d;
    logic [31:0]       data_wdata_q, data_wdata_d;
    logic              result_valid_q, result_valid_d;
    logic [31:0]       load_data_q, load_data_d;
    logic              adel_q, adel_d;
    logic              ades_q, ades_d;
    logic [ADDR_W-1:0] badvaddr_q, badvaddr_d;

    function automatic logic is_store(input logic [2:0] op);
        return op[2] & (op[1] | op[0]);
    endfunction

    function automatic logic misaligned(input logic [2:0] op, input logic [1:0] a);
        case (op)
            3'b010, 3'b011, 3'b110: return a[0];
            3'b100, 3'b111:         return a != 2'b00;
            default:                return 1'b0;
        endcase
    endfunction

    function automatic logic [1:0] size_of(input logic [2:0] op);
        case (op)
            3'b000, 3'b001, 3'b101: return 2'd0;
            3'b010, 3'b011, 3'b110: return 2'd1;
            default:                return 2'd2;
        endcase
    endfunction

    function automatic logic [3:0] strb_of(input logic [2:0] op, input logic [1:0] a);
        case (op)
            3'b101:  return 4'b0001 << a;
            3'b110:  return a[1] ? 4'b1100 : 4'b0011;
            3'b111:  return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

    // Narrow stores replicate the source across all lanes so the strobes
    // alone select the written bytes.
    function automatic logic [31:0] wdata_of(input logic [2:0] op, input logic [31:0] w);
        case (op)
            3'b101:  return {4{w[7:0]}};
            3'b110:  return {2{w[15:0]}};
            3'b111:  return w;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] extract(input logic [2:0] op, input logic [1:0] off,
                                            input logic [31:0] rdata);
        logic [31:0] byte_sh;
        logic [15:0] half;
        byte_sh = rdata >> {off, 3'b000};
        half    = off[1] ? rdata[31:16] : rdata[15:0];
        case (op)
            3'b000:  return {{24{byte_sh[7]}}, byte_sh[7:0]};
            3'b001:  return {24'd0, byte_sh[7:0]};
            3'b010:  return {{16{half[15]}}, half};
            3'b011:  return {16'd0, half};
            3'b100:  return rdata;
            default: return 32'd0;
        endcase
    endfunction

    always_comb begin
        state_d        = state_q;
        op_d           = op_q;
        flush_seen_d   = flush_seen_q;
        data_req_d     = data_req_q;
        data_wr_d      = data_wr_q;
        data_size_d    = data_size_q;
        data_wstrb_d   = data_wstrb_q;
        data_addr_d    = data_addr_q;
        data_wdata_d   = data_wdata_q;
        result_valid_d = result_valid_q;
        load_data_d    = load_data_q;
        adel_d         = adel_q;
        ades_d         = ades_q;
        badvaddr_d     = badvaddr_q;
        case (state_q)
            S_IDLE: begin
                if (mem_valid && !flush) begin
                    if (misaligned(mem_op, mem_addr[1:0])) begin
                        state_d        = S_DONE;
                        result_valid_d = 1'b1;
                        adel_d         = !is_store(mem_op);
                        ades_d         = is_store(mem_op);
                        badvaddr_d     = mem_addr;
                        load_data_d    = 32'd0;
                    end else begin
                        state_d      = S_REQ;
                        op_d         = mem_op;
                        flush_seen_d = 1'b0;
                        data_req_d   = 1'b1;
                        data_wr_d    = is_store(mem_op);
                        data_size_d  = size_of(mem_op);
                        data_wstrb_d = strb_of(mem_op, mem_addr[1:0]);
                        data_addr_d  = mem_addr;
                        data_wdata_d = wdata_of(mem_op, mem_wdata);
                    end
                end
            end
            S_REQ: begin
                // The request stays up until accepted; a flush only marks
                // the response as one to be discarded.
                if (flush) flush_seen_d = 1'b1;
                if (data_addr_ok) begin
                    data_req_d = 1'b0;
                    state_d    = (flush_seen_q || flush) ? S_CANCEL : S_WAIT;
                end
            end
            S_WAIT: begin
                if (data_data_ok) begin
                    if (flush) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d        = S_DONE;
                        result_valid_d = 1'b1;
                        load_data_d    = extract(op_q, data_addr_q[1:0], data_rdata);
                    end
                end else if (flush) begin
                    state_d = S_CANCEL;
                end
            end
            S_CANCEL: begin
                if (data_data_ok) state_d = S_IDLE;
            end
            S_DONE: begin
                if (flush || wb_allowin) begin
                    state_d        = S_IDLE;
                    result_valid_d = 1'b0;
                    load_data_d    = 32'd0;
                    adel_d         = 1'b0;
                    ades_d         = 1'b0;
                    badvaddr_d     = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q        <= S_IDLE;
            op_q           <= 3'd0;
            flush_seen_q   <= 1'b0;
            data_req_q     <= 1'b0;
            data_wr_q      <= 1'b0;
            data_size_q    <= 2'd0;
            data_wstrb_q   <= 4'd0;
            data_addr_q    <= '0;
            data_wdata_q   <= 32'd0;
            result_valid_q <= 1'b0;
            load_data_q    <= 32'd0;
            adel_q         <= 1'b0;
            ades_q         <= 1'b0;
            badvaddr_q     <= '0;
        end else begin
            state_q        <= state_d;
            op_q           <= op_d;
            flush_seen_q   <= flush_seen_d;
            data_req_q     <= data_req_d;
            data_wr_q      <= data_wr_d;
            data_size_q    <= data_size_d;
            data_wstrb_q   <= data_wstrb_d;
            data_addr_q    <= data_addr_d;
            data_wdata_q   <= data_wdata_d;
            result_valid_q <= result_valid_d;
            load_data_q    <= load_data_d;
            adel_q         <= adel_d;
            ades_q         <= ades_d;
            badvaddr_q     <= badvaddr_d;
        end
    end

    // A flush in IDLE kills the MEM instruction, so nothing is held. CANCEL
    // stalls any new op until the stale response has drained.
    assign mem_stall = mem_valid && (state_q != S_DONE) &&
                       !((state_q == S_IDLE) && flush);

    assign result_valid = result_valid_q;
    assign load_data    = load_data_q;
    assign adel         = adel_q;
    assign ades         = ades_q;
    assign badvaddr     = badvaddr_q;
    assign data_req     = data_req_q;
    assign data_wr      = data_wr_q;
    assign data_size    = data_size_q;
    assign data_wstrb   = data_wstrb_q;
    assign data_addr    = data_addr_q;
    assign data_wdata   = data_wdata_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_data_sram_ctrl.sv
// ---------------------------------------------------------------------------
// tb_data_sram_ctrl
//   Drives directed and randomized loads/stores, acts as the SRAM port with
//   random handshake latencies, and compares every observable result with a
//   transaction-level model of the access rules.
// ---------------------------------------------------------------------------
module tb_data_sram_ctrl;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        resetn;
    logic        mem_valid;
    logic [2:0]  mem_op;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        flush;
    logic        wb_allowin;
    logic        mem_stall;
    logic        result_valid;
    logic [31:0] load_data;
    logic        adel;
    logic        ades;
    logic [31:0] badvaddr;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic [31:0] data_rdata;
    logic        data_data_ok;
    logic [2:0]  dbg_state;

    data_sram_ctrl #(.ADDR_W(32)) dut (
        .clk(clk), .resetn(resetn),
        .mem_valid(mem_valid), .mem_op(mem_op), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .flush(flush), .wb_allowin(wb_allowin), .mem_stall(mem_stall),
        .result_valid(result_valid), .load_data(load_data), .adel(adel), .ades(ades),
        .badvaddr(badvaddr), .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_wstrb(data_wstrb), .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_rdata(data_rdata), .data_data_ok(data_data_ok),
        .dbg_state(dbg_state)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model ----------------
    function automatic bit m_is_store(input int op);
        return op >= 5;
    endfunction

    function automatic bit m_misaligned(input int op, input logic [31:0] addr);
        bit is_half = (op == 2) || (op == 3) || (op == 6);
        bit is_word = (op == 4) || (op == 7);
        return (is_half && (addr % 2 != 0)) || (is_word && (addr % 4 != 0));
    endfunction

    function automatic logic [1:0] m_size(input int op);
        if (op == 0 || op == 1 || op == 5) return 2'd0;
        if (op == 2 || op == 3 || op == 6) return 2'd1;
        return 2'd2;
    endfunction

    function automatic logic [3:0] m_strb(input int op, input logic [31:0] addr);
        int off = int'(addr % 4);
        if (op == 5) return 4'(1 << off);
        if (op == 6) return (off >= 2) ? 4'hC : 4'h3;
        if (op == 7) return 4'hF;
        return 4'h0;
    endfunction

    function automatic logic [31:0] m_wdata(input int op, input logic [31:0] w);
        logic [31:0] b = w & 32'hFF;
        logic [31:0] h = w & 32'hFFFF;
        if (op == 5) return b * 32'h0101_0101;
        if (op == 6) return h * 32'h0001_0001;
        return w;
    endfunction

    function automatic logic [31:0] m_load(input int op, input logic [31:0] addr,
                                           input logic [31:0] rdata);
        int off = int'(addr % 4);
        int v;
        case (op)
            0, 1: begin
                v = int'((rdata >> (8 * off)) & 32'hFF);
                if (op == 0 && v >= 128) v -= 256;
                return 32'(v);
            end
            2, 3: begin
                v = int'((rdata >> (16 * (off / 2))) & 32'hFFFF);
                if (op == 2 && v >= 32768) v -= 65536;
                return 32'(v);
            end
            4:       return rdata;
            default: return 32'd0;
        endcase
    endfunction

    // ---------------- driver tasks ----------------
    // Leave DONE: either WB takes the result or a flush kills it.
    task automatic finish_done(input bit do_flush);
        wb_allowin = do_flush ? 1'($urandom_range(0, 1)) : 1'b1;
        flush      = do_flush;
        mem_valid  = 1'b0;
        tick();
        wb_allowin = 1'b0;
        flush      = 1'b0;
        chk("after_rv", result_valid, 0);
        chk("after_err", {adel, ades}, 0);
    endtask

    // fmode: 0 normal, 1 flush in first REQ cycle, 2 flush in first WAIT
    // cycle, 3 flush in DONE.
    task automatic do_access(input int op, input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [31:0] rdata, input int a_lat, input int d_lat,
                             input int wb_lat, input int fmode);
        bit mis = m_misaligned(op, addr);
        bit st  = m_is_store(op);
        mem_valid  = 1'b1;
        mem_op     = 3'(op);
        mem_addr   = addr;
        mem_wdata  = wdata;
        flush      = 1'b0;
        wb_allowin = 1'b0;
        #1 chk("stall_accept", mem_stall, 1);
        tick();
        if (mis) begin
            chk("mis_rv", result_valid, 1);
            chk("mis_adel", adel, !st);
            chk("mis_ades", ades, st);
            chk("mis_badv", badvaddr, addr);
            chk("mis_ld", load_data, 0);
            chk("mis_req", data_req, 0);
            chk("mis_stall", mem_stall, 0);
            for (int i = 0; i < wb_lat; i++) begin
                tick();
                chk("mis_hold_rv", result_valid, 1);
                chk("mis_hold_req", data_req, 0);
            end
            finish_done(fmode == 3);
            return;
        end
        chk("req_valid", data_req, 1);
        chk("req_wr", data_wr, st);
        chk("req_size", data_size, m_size(op));
        chk("req_strb", data_wstrb, m_strb(op, addr));
        chk("req_addr", data_addr, addr);
        if (st) chk("req_wdata", data_wdata, m_wdata(op, wdata));
        chk("req_stall", mem_stall, 1);
        if (fmode == 1) flush = 1'b1;
        for (int i = 0; i < a_lat; i++) begin
            tick();
            flush = 1'b0;
            if (fmode == 1) mem_valid = 1'b0;
            chk("req_hold", data_req, 1);
            chk("req_hold_addr", data_addr, addr);
        end
        data_addr_ok = 1'b1;
        tick();
        data_addr_ok = 1'b0;
        flush        = 1'b0;
        chk("req_drop", data_req, 0);
        if (fmode == 1) mem_valid = 1'b0;
        if (fmode == 2) begin
            flush     = 1'b1;
            mem_valid = 1'b0;
        end
        for (int i = 0; i < d_lat; i++) begin
            tick();
            flush = 1'b0;
            chk("wait_rv", result_valid, 0);
            chk("wait_req", data_req, 0);
            if (fmode == 0 || fmode == 3) chk("wait_stall", mem_stall, 1);
        end
        data_data_ok = 1'b1;
        data_rdata   = rdata;
        tick();
        data_data_ok = 1'b0;
        data_rdata   = $urandom;
        flush        = 1'b0;
        if (fmode == 1 || fmode == 2) begin
            chk("cancel_rv", result_valid, 0);
            chk("cancel_req", data_req, 0);
            mem_valid = 1'b0;
            return;
        end
        exp_q.push_back(m_load(op, addr, rdata));
        chk("res_rv", result_valid, 1);
        chk("res_data", load_data, exp_q.pop_front());
        chk("res_err", {adel, ades}, 0);
        chk("res_stall", mem_stall, 0);
        for (int i = 0; i < wb_lat; i++) begin
            tick();
            chk("hold_rv", result_valid, 1);
            chk("hold_data", load_data, m_load(op, addr, rdata));
            chk("hold_req", data_req, 0);
        end
        finish_done(fmode == 3);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    // ---------------- stimulus ----------------
    initial begin
        resetn       = 1'b1;
        mem_valid    = 1'b0;
        mem_op       = 3'd0;
        mem_addr     = 32'd0;
        mem_wdata    = 32'd0;
        flush        = 1'b0;
        wb_allowin   = 1'b0;
        data_addr_ok = 1'b0;
        data_rdata   = 32'd0;
        data_data_ok = 1'b0;
        #2 resetn = 1'b0;
        #1;
        chk("rst_req", data_req, 0);
        chk("rst_rv", result_valid, 0);
        chk("rst_stall", mem_stall, 0);
        chk("rst_fields", {data_wr, data_size, data_wstrb, adel, ades}, 0);
        chk("rst_addr", data_addr, 0);
        chk("rst_ld", load_data, 0);
        repeat (3) tick();
        resetn = 1'b1;
        tick();

        // Directed cases from the access rules.
        do_access(0, 32'h1000_0003, 32'h0, 32'h80AB_CD12, 0, 2, 0, 0);
        do_access(6, 32'h0000_2002, 32'h1234_5678, 32'h0, 1, 1, 1, 0);
        do_access(4, 32'h0000_2001, 32'h0, 32'h0, 0, 0, 1, 0);
        do_access(7, 32'h0000_2001, 32'h0, 32'h0, 0, 0, 0, 0);
        do_access(3, 32'h0000_4002, 32'h0, 32'h9ABC_0000, 0, 0, 4, 0);

        // Flush in REQ with a late addr_ok; a new LW waits out the stale
        // response before issuing.
        mem_valid = 1'b1;
        mem_op    = 3'd4;
        mem_addr  = 32'h0000_3000;
        tick();
        chk("fl_req", data_req, 1);
        flush = 1'b1;
        tick();
        flush     = 1'b0;
        mem_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            chk("fl_req_hold", data_req, 1);
            tick();
        end
        chk("fl_req_hold", data_req, 1);
        data_addr_ok = 1'b1;
        tick();
        data_addr_ok = 1'b0;
        chk("fl_req_drop", data_req, 0);
        mem_valid = 1'b1;
        mem_op    = 3'd4;
        mem_addr  = 32'h0000_3004;
        #1 chk("fl_cancel_stall", mem_stall, 1);
        tick();
        chk("fl_cancel_req", data_req, 0);
        chk("fl_cancel_stall", mem_stall, 1);
        data_data_ok = 1'b1;
        data_rdata   = 32'hDEAD_BEEF;
        tick();
        data_data_ok = 1'b0;
        chk("fl_cancel_rv", result_valid, 0);
        chk("fl_idle_req", data_req, 0);
        do_access(4, 32'h0000_3004, 32'h0, 32'h1357_9BDF, 0, 0, 0, 0);

        // Reset while waiting for data_ok.
        mem_valid = 1'b1;
        mem_op    = 3'd4;
        mem_addr  = 32'h0000_0100;
        tick();
        data_addr_ok = 1'b1;
        tick();
        data_addr_ok = 1'b0;
        mem_valid    = 1'b0;
        tick();
        #2 resetn = 1'b0;
        #1;
        chk("rstw_req", data_req, 0);
        chk("rstw_size", data_size, 0);
        chk("rstw_addr", data_addr, 0);
        chk("rstw_rv", result_valid, 0);
        tick();
        resetn = 1'b1;
        tick();
        do_access(1, 32'h0000_0000, 32'h0, 32'h0000_00F0, 0, 0, 0, 0);

        // Randomized accesses, latencies and flush placements.
        for (int n = 0; n < 80; n++) begin
            int op    = $urandom_range(0, 7);
            int sel   = $urandom_range(0, 9);
            int fmode = (sel <= 6) ? 0 : sel - 6;
            do_access(op, $urandom, $urandom, $urandom, $urandom_range(0, 3),
                      $urandom_range(0, 3), $urandom_range(0, 3), fmode);
        end

        chk("sb_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
